collatz_engine: RTL
===================

Name: collatz_engine

Overview:
- Sequential Collatz iterator that sits directly upstream of the binary-to-decimal digit decoder.
- Accepts a seed through a start/ready handshake and applies one Collatz step per clock: n/2 if even, 3n+1 if odd.
- Counts steps until n reaches 1 and tracks the peak value.
- Publishes stable 16-bit-compatible binary results (steps, peak, live value) for decimal decoding and display.

Parameters:
- WIDTH, 16, width of seed, live value and peak; WIDTH=16 matches the decimal decoder input.
- STEP_WIDTH, 16, width of the step counter; the counter saturates at 2^STEP_WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a run; accepted only when ready=1.
- seed  input  WIDTH  starting value; sampled on the accept cycle.
- ready  output  1  engine is idle and can accept start.
- busy  output  1  a run is in progress (state RUN).
- done  output  1  one-cycle pulse; results are final.
- steps  output  STEP_WIDTH  number of steps taken.
- peak  output  WIDTH  largest value reached, including the seed.
- cur_value  output  WIDTH  current n; live during RUN, final value afterwards.
- status  output  2  00 ok, 01 zero seed, 10 overflow, 11 step timeout.

Behaviour:
- Clock and reset are decided: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: on any clk edge with reset=1:
  - state returns to IDLE;
  - steps, peak, cur_value, status and done are cleared to 0;
  - busy=0 and ready=1.
  - Reset mid-run aborts the run with no done pulse.
- States are IDLE, RUN and DONE.
  - ready=1 only in IDLE; busy=1 only in RUN; done=1 only in DONE.
- IDLE:
  - If start=1 at an edge: cur_value<=seed, peak<=seed, steps<=0, status<=00, next state RUN.
  - start in any other state is ignored; it is not queued.
- RUN: each edge evaluates n=cur_value in this priority order:
  1. n==0: status<=01, go to DONE.
  2. n==1: status<=00, go to DONE.
  3. steps==2^STEP_WIDTH-1: status<=11, go to DONE, value unchanged.
  4. n odd and 3n+1 >= 2^WIDTH: status<=10, go to DONE; cur_value, steps and peak unchanged.
  5. Otherwise: cur_value<=next, steps<=steps+1, peak<=max(peak,next).
- Next-value arithmetic:
  - Even n: next = n>>1.
  - Odd n: next = (n<<1)+n+1, computed at WIDTH+2 bits; any nonzero bit above WIDTH-1 is overflow.
  - Computed structurally using the existing adder cells.
- DONE: done=1 for exactly this one cycle, then unconditionally IDLE; start is ignored in this cycle.
- Output hold: steps, peak, cur_value and status stay unchanged from DONE until the next accepted start or reset.
- Latency: an accept at edge T gives done high in the cycle after edge T+1+k, where k = number of steps. For k=0 (seed 1 or 0), done is high in the cycle after edge T+1.
- Back-to-back runs: start may be asserted the cycle after done; the minimum accept spacing is k+3 cycles.

Test Plan:
- Seed 6, single start pulse -> done exactly 10 cycles after the accept cycle; steps=8, peak=16, cur_value=1, status=00; busy high for 9 cycles.
- Seed 27 -> steps=111, peak=9232, status=00; hold start high through DONE and confirm exactly one run occurs and the outputs stay stable afterwards.
- Seed 1 and seed 0 -> done 2 cycles after accept, steps=0; status=00 for seed 1 (peak=1) and 01 for seed 0 (peak=0).
- Seed 0xFFFF with WIDTH=16 -> status=10, steps=0, peak=0xFFFF, cur_value=0xFFFF, done asserted.
- Seed 7 with STEP_WIDTH=4 -> status=11, steps=15, cur_value=2, peak=52; with default STEP_WIDTH: steps=16, status=00.
- Seed 27, reset asserted 20 cycles into the run -> next edge gives ready=1 and all outputs 0, no done pulse; a following seed 6 run completes correctly.

Source files
------------

// File: rtl/collatz_engine_if.sv
// rtl/collatz_engine_if.sv - start/ready handshake and result bundle for the Collatz engine
interface collatz_engine_if #(
    parameter int WIDTH      = 16,
    parameter int STEP_WIDTH = 16
);
    logic                  start;
    logic [WIDTH-1:0]      seed;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [STEP_WIDTH-1:0] steps;
    logic [WIDTH-1:0]      peak;
    logic [WIDTH-1:0]      cur_value;
    logic [1:0]            status;

    modport master (
        output start, seed,
        input  ready, busy, done, steps, peak, cur_value, status
    );

    modport slave (
        input  start, seed,
        output ready, busy, done, steps, peak, cur_value, status
    );
endinterface

// File: rtl/collatz_engine.sv
// rtl/collatz_engine.sv - one Collatz step per clock with step count, peak and termination status
module collatz_engine #(
    parameter int WIDTH      = 16,
    parameter int STEP_WIDTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    collatz_engine_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_ZERO     = 2'b01;
    localparam logic [1:0] ST_OVERFLOW = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      cur_q, cur_d;
    logic [WIDTH-1:0]      peak_q, peak_d;
    logic [STEP_WIDTH-1:0] steps_q, steps_d;
    logic [1:0]            status_q, status_d;

    logic [WIDTH+1:0]      n_ext;
    logic [WIDTH+1:0]      triple;
    logic                  odd_overflow;
    logic [WIDTH-1:0]      next_val;

    // 3n+1 carried two bits wide so any bit above WIDTH-1 flags overflow
    assign n_ext        = {2'b00, cur_q};
    assign triple       = (n_ext << 1) + n_ext + (WIDTH+2)'(1);
    assign odd_overflow = |triple[WIDTH+1:WIDTH];
    assign next_val     = cur_q[0] ? triple[WIDTH-1:0] : (cur_q >> 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            peak_q   <= '0;
            steps_q  <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            peak_q   <= peak_d;
            steps_q  <= steps_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        peak_d   = peak_q;
        steps_d  = steps_q;
        status_d = status_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cur_d    = bus.seed;
                    peak_d   = bus.seed;
                    steps_d  = '0;
                    status_d = ST_OK;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (cur_q == '0) begin
                    status_d = ST_ZERO;
                    state_d  = S_DONE;
                end else if (cur_q == WIDTH'(1)) begin
                    status_d = ST_OK;
                    state_d  = S_DONE;
                end else if (&steps_q) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_DONE;
                end else if (cur_q[0] && odd_overflow) begin
                    status_d = ST_OVERFLOW;
                    state_d  = S_DONE;
                end else begin
                    cur_d   = next_val;
                    steps_d = steps_q + STEP_WIDTH'(1);
                    if (next_val > peak_q) begin
                        peak_d = next_val;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ready     = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.steps     = steps_q;
    assign bus.peak      = peak_q;
    assign bus.cur_value = cur_q;
    assign bus.status    = status_q;
endmodule
